// File: rtl/wb_trace_monitor_pkg.sv
// Shared definitions for the writeback trace monitor: FSM encoding and trace record layout.
package wb_trace_monitor_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } mon_state_e;

   localparam int RD_W = 5;

   // Record packs as {rd, data, pc} with pc in the low bits.
   function automatic int rec_w(input int data_w, input int pc_w);
      return RD_W + data_w + pc_w;
   endfunction

   function automatic int data_lsb(input int pc_w);
      return pc_w;
   endfunction

   function automatic int rd_lsb(input int data_w, input int pc_w);
      return data_w + pc_w;
   endfunction

endpackage

// File: rtl/wb_trace_monitor_trace_fifo.sv
// Synchronous show-ahead FIFO; the head entry is held in its own register.
module trace_fifo #(
   parameter int W     = 21,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic         valid,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic [W-1:0] head_q, head_d;
   logic         empty;
   logic         pop_ok;
   logic         push_ok;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign valid = !empty;
   assign rdata = head_q;

   always_comb begin
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      drop     = push && !push_ok;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q[AW-1:0]] = wdata;
         wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      // Reading the post-write array covers the push-into-empty bypass.
      head_d = mem_d[rd_ptr_d[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/wb_trace_monitor.sv
// Writeback trace monitor: records register-file writes, counts cycles/retires, detects program end.
//   state    | meaning
//   ST_RUN   | program executing; halt_req or cycle limit ends it
//   ST_DRAIN | halt seen; waiting for in-flight instructions to retire
//   ST_DONE  | finished; counters frozen, FIFO still poppable
module wb_trace_monitor
   import wb_trace_monitor_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int PC_W         = 8,
   parameter int DEPTH        = 8,
   parameter int CNT_W        = 16,
   parameter int DRAIN_CYCLES = 3,
   parameter int MAX_CYCLES   = 1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_en,
   input  logic [4:0]        wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [PC_W-1:0]   wb_pc,
   input  logic              halt_req,
   input  logic              trace_rd,
   output logic              trace_valid,
   output logic [4:0]        trace_rd_addr,
   output logic [DATA_W-1:0] trace_data,
   output logic [PC_W-1:0]   trace_pc,
   output logic              fifo_full,
   output logic              overflow,
   output logic [CNT_W-1:0]  retired_count,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              done,
   output logic              timeout
);

   localparam int REC_W    = rec_w(DATA_W, PC_W);
   localparam int DATA_LSB = data_lsb(PC_W);
   localparam int RD_LSB   = rd_lsb(DATA_W, PC_W);
   localparam int DRN_W    = (DRAIN_CYCLES < 3) ? 2 : $clog2(DRAIN_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);
   localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES);
   localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);
   localparam logic [DRN_W-1:0] DRN_TWO  = DRN_W'(2);

   mon_state_e       state_q, state_d;
   logic [DRN_W-1:0] drain_q, drain_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             overflow_q, overflow_d;
   logic             timeout_q, timeout_d;

   logic             accept;
   logic             push;
   logic             fifo_drop;
   logic [REC_W-1:0] push_rec;
   logic [REC_W-1:0] head_rec;

   assign push_rec = {wb_rd, wb_data, wb_pc};

   trace_fifo #(
      .W     (REC_W),
      .DEPTH (DEPTH)
   ) u_trace_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (push_rec),
      .pop   (trace_rd),
      .valid (trace_valid),
      .rdata (head_rec),
      .full  (fifo_full),
      .drop  (fifo_drop)
   );

   always_comb begin
      state_d    = state_q;
      drain_d    = drain_q;
      cycle_d    = cycle_q;
      retired_d  = retired_q;
      overflow_d = overflow_q | fifo_drop;
      timeout_d  = timeout_q;

      accept = wb_en && (state_q != ST_DONE);
      push   = accept && (wb_rd != 5'd0);

      if (accept && (retired_q != '1)) begin
         retired_d = retired_q + CNT_ONE;
      end
      if ((state_q != ST_DONE) && (cycle_q != '1)) begin
         cycle_d = cycle_q + CNT_ONE;
      end

      case (state_q)
         ST_RUN: begin
            if (cycle_q == CYC_LAST) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end else if (halt_req) begin
               state_d = ST_DRAIN;
               drain_d = DRN_LOAD;
            end
         end
         ST_DRAIN: begin
            drain_d = drain_q - DRN_ONE;
            if (cycle_q == CYC_LAST) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end else if (drain_q <= DRN_TWO) begin
               // Terminal count: the decremented value reaches 1.
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         drain_q    <= '0;
         cycle_q    <= '0;
         retired_q  <= '0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         drain_q    <= drain_d;
         cycle_q    <= cycle_d;
         retired_q  <= retired_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
      end
   end

   assign trace_rd_addr = head_rec[RD_LSB +: RD_W];
   assign trace_data    = head_rec[DATA_LSB +: DATA_W];
   assign trace_pc      = head_rec[PC_W-1:0];
   assign overflow      = overflow_q;
   assign retired_count = retired_q;
   assign cycle_count   = cycle_q;
   assign done          = (state_q == ST_DONE);
   assign timeout       = timeout_q;

endmodule
